// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if
//   Bundles the instruction-memory port, the fetch/decode handshake and the
//   redirect request of the fetch controller.
//   master : the fetch controller (drives address, instruction slot)
//   slave  : the surrounding memory/decode side
//   Signals:
//     o_Imem_Addr     byte address presented to instruction memory
//     i_Imem_Data     instruction word at o_Imem_Addr (combinational read)
//     o_Valid         o_Instr/o_Pc hold an instruction for decode
//     i_Ready         decode accepts o_Instr this cycle
//     o_Instr         registered instruction word
//     o_Pc            byte address o_Instr was fetched from
//     i_Redirect      branch/jump taken: flush and refetch
//     i_Redirect_Addr redirect target byte address
interface imem_fetch_ctrl_if;
    logic [31:0] o_Imem_Addr;
    logic [31:0] i_Imem_Data;
    logic        o_Valid;
    logic        i_Ready;
    logic [31:0] o_Instr;
    logic [31:0] o_Pc;
    logic        i_Redirect;
    logic [31:0] i_Redirect_Addr;

    modport master (
        output o_Imem_Addr,
        input  i_Imem_Data,
        output o_Valid,
        input  i_Ready,
        output o_Instr,
        output o_Pc,
        input  i_Redirect,
        input  i_Redirect_Addr
    );

    modport slave (
        input  o_Imem_Addr,
        output i_Imem_Data,
        input  o_Valid,
        output i_Ready,
        input  o_Instr,
        input  o_Pc,
        output i_Redirect,
        output i_Redirect_Addr
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Instruction fetch controller: walks a PC through instruction memory,
//   holds one fetched word in an output slot with a valid/ready handshake,
//   and handles redirects, halt words and address faults.
//   Ports:
//     i_Clk          clock, rising edge
//     i_Rst          asynchronous active-high reset
//     i_Start        begin/restart fetching from RESET_PC
//     bus            imem_fetch_ctrl_if.master (memory, decode handshake, redirect)
//     o_Halted       halt word (opcode 6'b111111) fetched
//     o_Fault        misaligned or out-of-range fetch/redirect address
//     o_Fetch_Count  completed valid&&ready handshakes, saturating
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset; nothing fetched until i_Start
//   FETCH | loading one word per free slot, PC advancing by 4
//   HALT  | halt word fetched; slot drains, no further loads
//   FAULT | bad fetch or redirect address; slot cleared until i_Start
module imem_fetch_ctrl #(
    parameter int          SIZE_IM  = 128,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Start,
    imem_fetch_ctrl_if.master      bus,
    output logic                   o_Halted,
    output logic                   o_Fault,
    output logic [15:0]            o_Fetch_Count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] SIZE_W    = 32'(SIZE_IM);
    localparam logic [31:0] INSTR_RST = 32'hFC00_0000;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [15:0] cnt_q;

    logic handshake;
    logic slot_free;
    logic pc_oor;
    logic redir_bad;
    logic is_halt_word;

    assign handshake    = valid_q && bus.i_Ready;
    assign slot_free    = !valid_q || bus.i_Ready;
    assign pc_oor       = {2'b00, pc_q[31:2]} >= SIZE_W;
    assign redir_bad    = (bus.i_Redirect_Addr[1:0] != 2'b00) ||
                          ({2'b00, bus.i_Redirect_Addr[31:2]} >= SIZE_W);
    assign is_halt_word = bus.i_Imem_Data[31:26] == 6'b111111;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= INSTR_RST;
            opc_q    <= 32'h0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= 16'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            opc_q    <= opc_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            // Counted in every state, including the edge a redirect flushes the slot
            if (handshake && (cnt_q != 16'hFFFF))
                cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        opc_d    = opc_q;
        halted_d = halted_q;
        fault_d  = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d = ST_FETCH;
                    pc_d    = RESET_PC;
                end
            end

            ST_FETCH: begin
                if (bus.i_Redirect) begin
                    // Flush even when decode is stalling; the old word is stale
                    valid_d = 1'b0;
                    if (redir_bad) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = bus.i_Redirect_Addr;
                    end
                end else if (slot_free) begin
                    if (pc_oor) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = bus.i_Imem_Data;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        if (is_halt_word) begin
                            // Halt word is still delivered; PC stays on it
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end else begin
                            pc_d = pc_q + 32'd4;
                        end
                    end
                end
            end

            ST_HALT: begin
                if (i_Start) begin
                    state_d  = ST_FETCH;
                    pc_d     = RESET_PC;
                    valid_d  = 1'b0;
                    halted_d = 1'b0;
                    fault_d  = 1'b0;
                end else if (handshake) begin
                    valid_d = 1'b0;
                end
            end

            ST_FAULT: begin
                valid_d = 1'b0;
                if (i_Start) begin
                    state_d  = ST_FETCH;
                    pc_d     = RESET_PC;
                    halted_d = 1'b0;
                    fault_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.o_Imem_Addr = pc_q;
    assign bus.o_Valid     = valid_q;
    assign bus.o_Instr     = instr_q;
    assign bus.o_Pc        = opc_q;
    assign o_Halted        = halted_q;
    assign o_Fault         = fault_q;
    assign o_Fetch_Count   = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl
//   Scoreboarded bench for imem_fetch_ctrl. The stimulus process pushes the
//   (pc, instr) pairs that decode should accept; a negedge monitor pops one
//   entry per handshake. Flag/count checks are made directly by stimulus.
//   A second instance with SIZE_IM=4 exercises the out-of-range fetch fault.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] W_ADDI = 32'h0010_0093;
    localparam logic [31:0] W_ADD  = 32'h0020_81B3;
    localparam logic [31:0] W_HALT = 32'hFC00_0000;
    localparam logic [31:0] W_ADD2 = 32'h0031_0233;
    localparam logic [31:0] W_ADDI5 = 32'h0050_0293;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic rst;
    logic start_a, start_b;
    logic halted_a, fault_a, halted_b, fault_b;
    logic [15:0] cnt_a, cnt_b;

    logic [31:0] mem_a [0:127];
    logic [31:0] mem_b [0:3];

    exp_t sbq[$];
    exp_t mon_e;

    int n_chk;
    int n_fail;

    imem_fetch_ctrl_if ifa ();
    imem_fetch_ctrl_if ifb ();

    imem_fetch_ctrl #(.SIZE_IM(128), .RESET_PC(32'h0)) dut_a (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Start       (start_a),
        .bus           (ifa.master),
        .o_Halted      (halted_a),
        .o_Fault       (fault_a),
        .o_Fetch_Count (cnt_a)
    );

    imem_fetch_ctrl #(.SIZE_IM(4), .RESET_PC(32'h0)) dut_b (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Start       (start_b),
        .bus           (ifb.master),
        .o_Halted      (halted_b),
        .o_Fault       (fault_b),
        .o_Fetch_Count (cnt_b)
    );

    assign ifa.i_Imem_Data = (ifa.o_Imem_Addr[31:9] == 23'd0) ? mem_a[ifa.o_Imem_Addr[8:2]] : 32'h0;
    assign ifb.i_Imem_Data = (ifb.o_Imem_Addr[31:4] == 28'd0) ? mem_b[ifb.o_Imem_Addr[3:2]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sbq.push_back(e);
    endtask

    // One pop per handshake; an edge with reset asserted is not a handshake
    always @(negedge clk) begin
        if (!rst && ifa.o_Valid && ifa.i_Ready) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h instr %h, expected no handshake", ifa.o_Pc, ifa.o_Instr);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_pc", ifa.o_Pc, mon_e.pc);
                chk("sb_instr", ifa.o_Instr, mon_e.instr);
            end
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 128; i++) mem_a[i] = 32'h0000_0013;
        mem_a[0]    = W_ADDI;
        mem_a[1]    = W_ADD;
        mem_a[2]    = W_HALT;
        for (int i = 0; i < 4; i++) mem_b[i] = W_ADDI + 32'(i);

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ifa.i_Ready = 1'b0;
        ifa.i_Redirect = 1'b0;
        ifa.i_Redirect_Addr = 32'h0;
        ifb.i_Ready = 1'b1;
        ifb.i_Redirect = 1'b0;
        ifb.i_Redirect_Addr = 32'h0;

        // Reset state
        #3;
        chk("rst_valid", 32'(ifa.o_Valid), 32'd0);
        chk("rst_instr", ifa.o_Instr, 32'hFC00_0000);
        chk("rst_pc", ifa.o_Pc, 32'h0);
        chk("rst_addr", ifa.o_Imem_Addr, 32'h0);
        chk("rst_flags", {30'd0, halted_a, fault_a}, 32'h0);
        chk("rst_count", 32'(cnt_a), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("idle_no_valid", 32'(ifa.o_Valid), 32'd0);

        // Stream to halt word, decode always ready
        ifa.i_Ready = 1'b1;
        push(32'h0, W_ADDI);
        push(32'h4, W_ADD);
        push(32'h8, W_HALT);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("lat_first_edge", 32'(ifa.o_Valid), 32'd0);
        tick();
        chk("lat_second_edge", 32'(ifa.o_Valid), 32'd1);
        chk("lat_pc0", ifa.o_Pc, 32'h0);
        tick();
        chk("stream_pc4", ifa.o_Pc, 32'h4);
        tick();
        chk("stream_pc8", ifa.o_Pc, 32'h8);
        chk("halt_set", 32'(halted_a), 32'd1);
        tick();
        chk("halt_valid_clr", 32'(ifa.o_Valid), 32'd0);
        chk("halt_count", 32'(cnt_a), 32'd3);
        tick();
        chk("halt_no_reload", 32'(ifa.o_Valid), 32'd0);

        // Backpressure at o_Pc=4, then redirect at o_Pc=8 while stalled
        mem_a[2]    = W_ADD2;
        mem_a[16]   = W_ADDI5;
        mem_a[17]   = W_HALT;
        ifa.i_Ready = 1'b0;
        start_a     = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_halt_clr", 32'(halted_a), 32'd0);
        push(32'h0, W_ADDI);
        push(32'h4, W_ADD);
        tick();
        ifa.i_Ready = 1'b1;
        tick();
        ifa.i_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_pc", ifa.o_Pc, 32'h4);
            chk("bp_instr", ifa.o_Instr, W_ADD);
            chk("bp_fetch_addr", ifa.o_Imem_Addr, 32'h8);
        end
        ifa.i_Ready = 1'b1;
        tick();
        ifa.i_Ready = 1'b0;
        chk("bp_release_pc8", ifa.o_Pc, 32'h8);
        chk("bp_count", 32'(cnt_a), 32'd5);
        ifa.i_Redirect      = 1'b1;
        ifa.i_Redirect_Addr = 32'h40;
        tick();
        ifa.i_Redirect = 1'b0;
        chk("redir_flush", 32'(ifa.o_Valid), 32'd0);
        chk("redir_addr", ifa.o_Imem_Addr, 32'h40);
        chk("redir_count", 32'(cnt_a), 32'd5);
        tick();
        chk("redir_target_pc", ifa.o_Pc, 32'h40);
        chk("redir_target_valid", 32'(ifa.o_Valid), 32'd1);
        push(32'h40, W_ADDI5);
        push(32'h44, W_HALT);
        ifa.i_Ready = 1'b1;
        tick();
        tick();
        chk("redir_run_halted", 32'(halted_a), 32'd1);
        chk("redir_run_count", 32'(cnt_a), 32'd7);

        // Misaligned redirect, handshake on the same edge still counted
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        push(32'h0, W_ADDI);
        tick();
        ifa.i_Redirect      = 1'b1;
        ifa.i_Redirect_Addr = 32'h42;
        tick();
        chk("rfault_set", 32'(fault_a), 32'd1);
        chk("rfault_valid", 32'(ifa.o_Valid), 32'd0);
        chk("rfault_pc_held", ifa.o_Imem_Addr, 32'h4);
        chk("rfault_count", 32'(cnt_a), 32'd8);
        ifa.i_Redirect_Addr = 32'h40;
        tick();
        chk("fault_ignores_redir", ifa.o_Imem_Addr, 32'h4);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        ifa.i_Redirect = 1'b0;
        ifa.i_Ready    = 1'b0;
        chk("start_clears_fault", 32'(fault_a), 32'd0);
        chk("start_beats_redir", ifa.o_Imem_Addr, 32'h0);
        tick();
        chk("after_fault_pc0", ifa.o_Pc, 32'h0);
        chk("after_fault_valid", 32'(ifa.o_Valid), 32'd1);

        // Asynchronous reset between edges with a word pending
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ifa.o_Valid), 32'd0);
        chk("arst_instr", ifa.o_Instr, 32'hFC00_0000);
        chk("arst_pc", ifa.o_Pc, 32'h0);
        chk("arst_count", 32'(cnt_a), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_idle", 32'(ifa.o_Valid), 32'd0);

        // Small memory: run off the end
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("small_pc", ifb.o_Pc, 32'(i * 4));
            chk("small_instr", ifb.o_Instr, W_ADDI + 32'(i));
        end
        tick();
        chk("oor_fault", 32'(fault_b), 32'd1);
        chk("oor_pc_held", ifb.o_Imem_Addr, 32'h10);
        chk("oor_valid", 32'(ifb.o_Valid), 32'd0);
        chk("oor_count", 32'(cnt_b), 32'd4);
        tick();
        chk("oor_no_fetch", 32'(ifb.o_Valid), 32'd0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("oor_start_clr", 32'(fault_b), 32'd0);
        tick();
        chk("oor_restart_pc0", ifb.o_Pc, 32'h0);
        chk("oor_restart_valid", 32'(ifb.o_Valid), 32'd1);

        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending entries, expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter SIZE_IM, default 128, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after start.
REQ-003 SHALL have port i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_Start  input  1  begin or restart fetching from RESET_PC.
REQ-006 SHALL have port o_Imem_Addr  output  32  byte address to instruction memory; always equals the internal PC.
REQ-007 SHALL have port i_Imem_Data  input  32  instruction word read combinationally at o_Imem_Addr.
REQ-008 SHALL have port o_Valid  output  1  o_Instr/o_Pc hold an instruction for decode.
REQ-009 SHALL have port i_Ready  input  1  decode accepts o_Instr this cycle.
REQ-010 SHALL have port o_Instr  output  32  registered instruction word.
REQ-011 SHALL have port o_Pc  output  32  byte address o_Instr was fetched from.
REQ-012 SHALL have port i_Redirect  input  1  branch/jump taken; flush and refetch.
REQ-013 SHALL have port i_Redirect_Addr  input  32  redirect target byte address.
REQ-014 SHALL have port o_Halted  output  1  halt word (opcode 6'b111111) fetched.
REQ-015 SHALL have port o_Fault  output  1  misaligned or out-of-range fetch/redirect address.
REQ-016 SHALL have port o_Fetch_Count  output  16  number of completed o_Valid&&i_Ready handshakes.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, HALT, FAULT; IDLE after reset.
REQ-018 IDLE: no fetch, o_Valid=0; i_Start -> FETCH next cycle, PC=RESET_PC.
REQ-019 FETCH: load slot when (!o_Valid || i_Ready): o_Instr<=i_Imem_Data, o_Pc<=PC, o_Valid<=1, PC<=PC+4 (32-bit wrap).
REQ-020 FETCH: when the slot is occupied and !i_Ready, o_Instr, o_Pc, o_Valid and PC SHALL hold.
REQ-021 Latency: first o_Valid=1 two cycles after i_Start is sampled in IDLE; one instruction per cycle when i_Ready=1 continuously.
REQ-022 Loaded word with [31:26]==6'b111111 SHALL be delivered normally, then FSM -> HALT, o_Halted<=1 in the same edge; PC not incremented.
REQ-023 HALT: no further loads; pending halt word stays valid until accepted, then o_Valid<=0.
REQ-024 FETCH with (PC>>2)>=SIZE_IM at a load opportunity: no load, FSM -> FAULT, o_Fault<=1, PC held.
REQ-025 i_Redirect in FETCH: highest priority over load; o_Valid<=0 (slot flushed even if !i_Ready), PC<=i_Redirect_Addr.
REQ-026 Redirect target with [1:0]!=0 or ([31:2])>=SIZE_IM: FSM -> FAULT, o_Fault<=1, o_Valid<=0, PC unchanged.
REQ-027 i_Redirect in IDLE, HALT, FAULT SHALL be ignored; i_Start in FETCH SHALL be ignored.
REQ-028 i_Start in HALT or FAULT: -> FETCH, PC<=RESET_PC, o_Valid<=0, o_Halted<=0, o_Fault<=0; wins over simultaneous i_Redirect.
REQ-029 FAULT: o_Valid<=0 next edge; no fetch until i_Start.
REQ-030 o_Fetch_Count SHALL increment on each o_Valid&&i_Ready edge in any state, saturating at 16'hFFFF; not cleared by i_Start.
REQ-031 Handshake on the same edge as a redirect SHALL still be counted.

Reset
REQ-032 i_Rst=1 SHALL immediately force: state IDLE, PC=RESET_PC, o_Valid=0, o_Instr=32'hFC00_0000, o_Pc=0, o_Halted=0, o_Fault=0, o_Fetch_Count=0.
REQ-033 Reset asserted mid-fetch or mid-handshake SHALL discard the pending instruction; no count increment for that edge.
REQ-034 After i_Rst deasserts, block SHALL remain in IDLE until i_Start.

Verification
REQ-035 Stream: mem[0..2]=ADDI,ADD,FC000000; i_Start, i_Ready=1 -> o_Pc 0,4,8 on consecutive cycles, then o_Halted=1, o_Valid=0, count=3.
REQ-036 Backpressure: i_Ready=0 for 3 cycles at o_Pc=4 -> o_Instr/o_Pc/PC stable; release -> o_Pc=8 next cycle, no word lost or duplicated.
REQ-037 Redirect: at o_Pc=8 with i_Ready=0, i_Redirect=1, addr=0x40 -> o_Valid=0 next cycle, then o_Pc=0x40; count unchanged.
REQ-038 Fault: redirect addr=0x42 -> o_Fault=1, FSM FAULT; separately SIZE_IM=4, run past 0x0C -> o_Fault=1 at PC=0x10; i_Start clears both, o_Pc=0 follows.
REQ-039 Async reset: assert i_Rst between clock edges while o_Valid=1 -> outputs at REQ-032 values before next edge, count=0.
